// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared constants for the EX-stage ALU issue path:
//   - ALU op codes (RV32I base ops and the M-extension ops)
//   - issue FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//   - op_t: one issued operation (operands, op code, destination tag)
//   - is_muldiv(): true for the M-extension class, which settles later in the ALU
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int SEL_W = 5;
  localparam int RD_W  = 5;

  typedef enum logic [SEL_W-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  data1;
    logic [XLEN-1:0]  data2;
    logic [SEL_W-1:0] select;
    logic [RD_W-1:0]  rd;
  } op_t;

  // Codes outside the M-extension range (including unused encodings) fall
  // into the base class.
  function automatic logic is_muldiv(input logic [SEL_W-1:0] sel);
    case (sel)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_if
// Bundles the three buses around the ALU issue controller:
//   in_*   : ID/EX op handshake   (in_valid/in_ready, operands, op code, rd tag)
//   alu_*  : operands/op code driven to the ALU, result returned from it
//   out_*  : result handshake to EX/MEM (out_valid/out_ready, result, rd tag)
//   stall  : hazard-unit stall indication
// Modports:
//   master : the controller (alu_issue_ctrl)
//   slave  : its environment (upstream stage, ALU, downstream stage)
// -----------------------------------------------------------------------------
interface alu_issue_ctrl_if import alu_issue_ctrl_pkg::*; ();

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_data1;
  logic [XLEN-1:0]  in_data2;
  logic [SEL_W-1:0] in_select;
  logic [RD_W-1:0]  in_rd;

  logic [XLEN-1:0]  alu_data1;
  logic [XLEN-1:0]  alu_data2;
  logic [SEL_W-1:0] alu_select;
  logic [XLEN-1:0]  alu_result;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [RD_W-1:0]  out_rd;

  logic             stall;

  modport master (
    input  in_valid, in_data1, in_data2, in_select, in_rd,
    input  alu_result,
    input  out_ready,
    output in_ready,
    output alu_data1, alu_data2, alu_select,
    output out_valid, out_result, out_rd,
    output stall
  );

  modport slave (
    output in_valid, in_data1, in_data2, in_select, in_rd,
    output alu_result,
    output out_ready,
    input  in_ready,
    input  alu_data1, alu_data2, alu_select,
    input  out_valid, out_result, out_rd,
    input  stall
  );

endinterface

// File: rtl/alu_issue_ctrl_classifier.sv
// -----------------------------------------------------------------------------
// alu_op_classifier
// Purely combinational: maps an ALU op code to the number of extra cycles the
// operands must be held after the accept cycle (LAT-1). Kept separate so the
// hazard unit can instantiate the same mapping.
// Parameters:
//   BASE_LAT   hold latency of base ops and unknown codes (>= 1)
//   MULDIV_LAT hold latency of M-extension ops (>= 1)
//   CNT_W      width of the hold count; must hold max(BASE_LAT, MULDIV_LAT)
// Ports:
//   i_select   ALU op code
//   o_hold     LAT-1 for that op code
// -----------------------------------------------------------------------------
module alu_op_classifier
  import alu_issue_ctrl_pkg::*;
#(
  parameter int BASE_LAT   = 1,
  parameter int MULDIV_LAT = 2,
  parameter int CNT_W      = 4
) (
  input  logic [SEL_W-1:0] i_select,
  output logic [CNT_W-1:0] o_hold
);

  localparam logic [CNT_W-1:0] BASE_HOLD   = CNT_W'(BASE_LAT - 1);
  localparam logic [CNT_W-1:0] MULDIV_HOLD = CNT_W'(MULDIV_LAT - 1);

  logic w_is_muldiv;

  assign w_is_muldiv = is_muldiv(i_select);
  assign o_hold      = w_is_muldiv ? MULDIV_HOLD : BASE_HOLD;

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Initiator side of the EX-stage ALU interface. Accepts one op per in_valid/
// in_ready handshake, registers it onto alu_data1/alu_data2/alu_select and
// holds it there for a class-dependent number of cycles (mul/div settles later
// than base ops), then captures alu_result and offers it downstream with
// out_valid/out_ready backpressure. A finished result can be handed off in the
// same cycle the next op is accepted, so back-to-back issue has no bubble.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous, active-high reset
//   bus (master)   in_* op handshake, alu_* ALU bus, out_* result handshake,
//                  stall = in_valid && !in_ready
//   o_perf_ops     (ALU_ISSUE_PERF_EN only) accepted-op count, wraps at 2^32
//   o_perf_stalls  (ALU_ISSUE_PERF_EN only) stall-cycle count, wraps at 2^32
//
// Configuration macro: ALU_ISSUE_PERF_EN adds the two performance counters.
// Without it there are no counter ports and no counter logic.
// -----------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int BASE_LAT   = 1,
  parameter int MULDIV_LAT = 2,
  parameter int CNT_W      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  alu_issue_ctrl_if.master bus
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      o_perf_ops,
  output logic [31:0]      o_perf_stalls
`endif
);

  state_e           r_state;
  state_e           w_next_state;
  op_t              r_op;
  op_t              w_in_op;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_hold;
  logic [XLEN-1:0]  r_out_result;
  logic [RD_W-1:0]  r_out_rd;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_capture;
  logic             w_release;
  logic             w_stall;

  // ---------------------------------------------------------------------------
  // Latency class of the incoming op
  // ---------------------------------------------------------------------------
  alu_op_classifier #(
    .BASE_LAT   (BASE_LAT),
    .MULDIV_LAT (MULDIV_LAT),
    .CNT_W      (CNT_W)
  ) u_classifier (
    .i_select (bus.in_select),
    .o_hold   (w_hold)
  );

  assign w_in_op = '{
    data1  : bus.in_data1,
    data2  : bus.in_data2,
    select : bus.in_select,
    rd     : bus.in_rd
  };

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // Ready is gated by reset so nothing upstream sees a handshake while the
  // block is being cleared. In DONE, ready depends on out_ready: the slot only
  // frees up in the cycle the held result is taken.
  assign w_in_ready = !i_rst &&
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_DONE) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_stall    = bus.in_valid && !w_in_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a value unassigned and infer a latch.
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_release    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          w_release    = 1'b1;
          w_next_state = w_accept ? ST_BUSY : ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand slice, hold counter and result slice
  // ---------------------------------------------------------------------------
  // The operand slice only loads on an accept, so the ALU inputs cannot move
  // while an op is in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: every datapath register is reset, not just the control state:
    // the ALU bus and the result bus must read as zero right after reset,
    // including when reset lands in the middle of an op.
    if (i_rst) begin
      r_op         <= '0;
      r_cnt        <= '0;
      r_out_result <= '0;
      r_out_rd     <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so each register here
      // samples the values from before the edge regardless of statement order.
      if (w_accept) begin
        r_op  <= w_in_op;
        r_cnt <= w_hold;
      end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_capture) begin
        r_out_result <= bus.alu_result;
        r_out_rd     <= r_op.rd;
        r_out_valid  <= 1'b1;
      end else if (w_release) begin
        // Result and tag are left in place; only valid drops.
        r_out_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perf_ops    <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_accept) begin
        r_perf_ops <= r_perf_ops + 32'd1;
      end
      if (w_stall) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign o_perf_ops    = r_perf_ops;
  assign o_perf_stalls = r_perf_stalls;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready   = w_in_ready;
  assign bus.stall      = w_stall;
  assign bus.alu_data1  = r_op.data1;
  assign bus.alu_data2  = r_op.data2;
  assign bus.alu_select = r_op.select;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_rd     = r_out_rd;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Bench for alu_issue_ctrl with a behavioural ALU on the alu_* bus. Expected
// results, tags and latencies are queued when an op is offered and popped by
// a monitor when a result is handed off downstream.
// Optional macro: ALU_ISSUE_PERF_EN (connects and checks the perf counters).
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int BASE_LAT   = 1;
  localparam int MULDIV_LAT = 2;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;      // 0: latency not checked (result held back)
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl_if bus ();

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_stalls;
`endif

  alu_issue_ctrl #(
    .BASE_LAT   (BASE_LAT),
    .MULDIV_LAT (MULDIV_LAT),
    .CNT_W      (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .o_perf_ops    (perf_ops),
    .o_perf_stalls (perf_stalls)
`endif
  );

  // ---------------------------------------------------------------------------
  // Behavioural ALU (division by zero yields 0)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] alu_model(input logic [4:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (sel)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_SLL:    return a << b[4:0];
      ALU_SLT:    return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   return {31'd0, a < b};
      ALU_XOR:    return a ^ b;
      ALU_SRL:    return a >> b[4:0];
      ALU_SRA:    return 32'($signed(a) >>> b[4:0]);
      ALU_OR:     return a | b;
      ALU_AND:    return a & b;
      ALU_MUL:    return a * b;
      ALU_MULH: begin
        p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        return p[63:32];
      end
      ALU_MULHSU: begin
        p = 64'($signed({{32{a[31]}}, a}) * $signed({32'd0, b}));
        return p[63:32];
      end
      ALU_MULHU: begin
        p = {32'd0, a} * {32'd0, b};
        return p[63:32];
      end
      ALU_DIV:    return (b == 0) ? 32'd0 : (ovf ? a : 32'($signed(a) / $signed(b)));
      ALU_DIVU:   return (b == 0) ? 32'd0 : a / b;
      ALU_REM:    return (b == 0) ? 32'd0 : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
      ALU_REMU:   return (b == 0) ? 32'd0 : a % b;
      default:    return 32'd0;
    endcase
  endfunction

  always_comb bus.alu_result = alu_model(bus.alu_select, bus.alu_data1, bus.alu_data2);

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: one pop per downstream handshake
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got result=%h rd=%0d, required no result", bus.out_result, bus.out_rd);
      end else begin
        mon_e = sb_q.pop_front();
        n_checks++;
        if (bus.out_result !== mon_e.res || bus.out_rd !== mon_e.rd) begin
          n_errors++;
          $display("FAIL sb_result: got result=%h rd=%0d, required result=%h rd=%0d",
                   bus.out_result, bus.out_rd, mon_e.res, mon_e.rd);
        end
        if (mon_e.lat > 0) begin
          n_checks++;
          if (cyc - mon_e.acc_cyc != mon_e.lat) begin
            n_errors++;
            $display("FAIL sb_latency: got %0d cycles, required %0d (rd=%0d)",
                     cyc - mon_e.acc_cyc, mon_e.lat, mon_e.rd);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Offers an op from posedge+1; returns at posedge+1 after the accept edge
  // with in_valid still high. stalls = cycles it waited with stall=1.
  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int lat,
                       output int stalls);
    exp_t e;
    stalls        = 0;
    bus.in_valid  = 1'b1;
    bus.in_select = sel;
    bus.in_data1  = a;
    bus.in_data2  = b;
    bus.in_rd     = rd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        e = '{res: exp_res, rd: rd, lat: lat, acc_cyc: cyc + 1};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
      if (bus.stall === 1'b1) stalls++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_errors++;
    $display("FAIL issue_timeout: sel=%0d rd=%0d never accepted, required accept within 20 cycles", sel, rd);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.in_data1  = 32'hDEAD_BEEF;
    bus.in_data2  = 32'h1234_5678;
    bus.in_select = ALU_MUL;
    bus.in_rd     = 5'd31;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.alu_data1, bus.alu_data2, bus.alu_select, bus.out_result, bus.out_rd} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got valid=%b d1=%h d2=%h sel=%0d res=%h rd=%0d, required all 0",
               bus.out_valid, bus.alu_data1, bus.alu_data2, bus.alu_select, bus.out_result, bus.out_rd);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.stall !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready: got in_ready=%b stall=%b, required 0/1", bus.in_ready, bus.stall);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.stall !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got in_ready=%b stall=%b, required 1/0", bus.in_ready, bus.stall);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    int st;
    bus.out_ready = 1'b1;
    issue(ALU_ADD, 32'd5, 32'd7, 5'd3, 32'd12, BASE_LAT, st);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.stall !== 1'b0) st++;
    end
    n_checks++;
    if (st != 0) begin
      n_errors++;
      $display("FAIL add_stall: got %0d stall cycles, required 0", st);
    end
    drain("add");
  endtask

  task automatic test_mul();
    int st;
    bus.out_ready = 1'b1;
    issue(ALU_MUL, 32'd6, 32'd7, 5'd5, 32'd42, MULDIV_LAT, st);
    // A second op arrives while the MUL is in flight.
    bus.in_select = ALU_ADD;
    bus.in_data1  = 32'd9;
    bus.in_data2  = 32'd1;
    bus.in_rd     = 5'd6;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.alu_data1 !== 32'd6 || bus.alu_data2 !== 32'd7 || bus.alu_select !== ALU_MUL) begin
        n_errors++;
        $display("FAIL mul_hold%0d: got d1=%h d2=%h sel=%0d, required 6/7/%0d",
                 i, bus.alu_data1, bus.alu_data2, bus.alu_select, ALU_MUL);
      end
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.stall !== 1'b1) begin
        n_errors++;
        $display("FAIL mul_stall%0d: got in_ready=%b stall=%b, required 0/1", i, bus.in_ready, bus.stall);
      end
      @(posedge clk);
      #1;
    end
    issue(ALU_ADD, 32'd9, 32'd1, 5'd6, 32'd10, BASE_LAT, st);
    bus.in_valid = 1'b0;
    drain("mul");
  endtask

  task automatic test_divide();
    int st;
    bus.out_ready = 1'b1;
    issue(ALU_DIVU, 32'd100, 32'd0, 5'd1, 32'd0, MULDIV_LAT, st);
    issue(ALU_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, MULDIV_LAT, st);
    bus.in_valid = 1'b0;
    n_checks++;
    if (st != MULDIV_LAT) begin
      n_errors++;
      $display("FAIL divide_stall: got %0d stall cycles behind DIVU, required %0d", st, MULDIV_LAT);
    end
    drain("divide");
  endtask

  task automatic test_backpressure();
    int st;
    bus.out_ready = 1'b0;
    issue(ALU_SUB, 32'd3, 32'd5, 5'd7, 32'hFFFF_FFFE, 0, st);
    // The next op is queued while the result is held back.
    bus.in_select = ALU_ADD;
    bus.in_data1  = 32'd10;
    bus.in_data2  = 32'd20;
    bus.in_rd     = 5'd8;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFF_FFFE || bus.out_rd !== 5'd7) begin
        n_errors++;
        $display("FAIL bp_hold%0d: got valid=%b res=%h rd=%0d, required 1/fffffffe/7",
                 i, bus.out_valid, bus.out_result, bus.out_rd);
      end
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.stall !== 1'b1) begin
        n_errors++;
        $display("FAIL bp_ready%0d: got in_ready=%b stall=%b, required 0/1", i, bus.in_ready, bus.stall);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    issue(ALU_ADD, 32'd10, 32'd20, 5'd8, 32'd30, BASE_LAT, st);
    bus.in_valid = 1'b0;
    n_checks++;
    if (st != 0) begin
      n_errors++;
      $display("FAIL bp_bubble: got %0d wait cycles after release, required 0", st);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_valid_drop: got out_valid=%b in accept-following cycle, required 0", bus.out_valid);
    end
    drain("bp");
  endtask

  task automatic test_reset_mid();
    int st;
    bus.out_ready = 1'b1;
    issue(ALU_DIV, 32'd50, 32'd5, 5'd4, 32'd10, MULDIV_LAT, st);
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.alu_select !== ALU_DIV || bus.alu_data1 !== 32'd50) begin
      n_errors++;
      $display("FAIL rmid_busy: got sel=%0d d1=%h, required %0d/32", bus.alu_select, bus.alu_data1, ALU_DIV);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.alu_data1, bus.alu_data2, bus.alu_select,
         bus.out_result, bus.out_rd} !== '0) begin
      n_errors++;
      $display("FAIL rmid_outputs: got valid=%b rdy=%b d1=%h d2=%h sel=%0d res=%h rd=%0d, required all 0",
               bus.out_valid, bus.in_ready, bus.alu_data1, bus.alu_data2, bus.alu_select,
               bus.out_result, bus.out_rd);
    end
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(ALU_ADD, 32'd1, 32'd1, 5'd9, 32'd2, BASE_LAT, st);
    bus.in_valid = 1'b0;
    drain("rmid");
  endtask

  task automatic test_back_to_back();
    int st;
    int total_st;
    int acc[3];
    logic [31:0] a_v[3];
    logic [31:0] b_v[3];
    a_v = '{32'd2, 32'd4, 32'd7};
    b_v = '{32'd3, 32'd5, 32'd8};
    // Fresh reset so the perf counters start from zero.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    total_st = 0;
    for (int i = 0; i < 3; i++) begin
      issue(ALU_MUL, a_v[i], b_v[i], 5'(10 + i), a_v[i] * b_v[i], MULDIV_LAT, st);
      acc[i] = cyc;
      total_st += st;
    end
    bus.in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] != MULDIV_LAT + 1) begin
        n_errors++;
        $display("FAIL b2b_spacing%0d: got %0d cycles between accepts, required %0d",
                 i, acc[i] - acc[i-1], MULDIV_LAT + 1);
      end
    end
    drain("b2b");
`ifdef ALU_ISSUE_PERF_EN
    n_checks++;
    if (perf_ops !== 32'd3) begin
      n_errors++;
      $display("FAIL perf_ops: got %0d, required 3", perf_ops);
    end
    n_checks++;
    if (perf_stalls !== 32'(total_st)) begin
      n_errors++;
      $display("FAIL perf_stalls: got %0d, required %0d", perf_stalls, total_st);
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data1  = '0;
    bus.in_data2  = '0;
    bus.in_select = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_divide();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
